// File: rtl/xts_key_scheduler.sv
// xts_key_scheduler: buffers 512-bit candidate master keys in a small FIFO and
// feeds them one at a time to a serpent_xts header-check engine. The engine is
// soft-reset between attempts. The run stops on the first match, on an engine
// timeout, on abort, or once the last candidate has been tried.
module xts_key_scheduler #(
  parameter int FIFO_DEPTH = 4,
  parameter int IDX_W      = 32,
  parameter int TIMEOUT    = 4096
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [127:0]     i_header,
  input  logic             i_cand_valid,
  output logic             o_cand_ready,
  input  logic [511:0]     i_cand_key,
  input  logic             i_cand_last,
  output logic             o_xts_rstn,
  output logic             o_xts_key_valid,
  output logic [511:0]     o_xts_key,
  output logic [127:0]     o_xts_data,
  input  logic             i_xts_data_valid,
  input  logic             i_xts_compare_valid,
  input  logic [127:0]     i_xts_data,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_found,
  output logic             o_timeout,
  output logic [511:0]     o_match_key,
  output logic [IDX_W-1:0] o_match_index,
  output logic [IDX_W-1:0] o_attempts,
  output logic [127:0]     o_plain
);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int WD_W = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {S_IDLE, S_READY, S_WAIT, S_RECOVER, S_FINISH} state_e;
  state_e state_q, state_d;

  // candidate FIFO
  logic [511:0]  mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          last_seen_q;

  // engine handshake / status
  logic [511:0]      xts_key_q;
  logic              xts_key_valid_q;
  logic [127:0]      xts_data_q;
  logic [WD_W-1:0]   wdog_q;
  logic              dv_prev_q;
  logic              rec_q;
  logic              busy_q, done_q, found_q, timeout_q;
  logic [511:0]      match_key_q;
  logic [IDX_W-1:0]  match_index_q, attempts_q;
  logic [127:0]      plain_q;

  logic full, push, pop, start_run, hit, miss, to_evt, enter_finish, dv_edge, wd_expired;

  assign full         = (count_q == (AW+1)'(FIFO_DEPTH));
  assign o_cand_ready = busy_q && !full && !last_seen_q;
  assign push         = i_cand_valid && o_cand_ready;
  // engine valid is sticky, so only its rising edge marks a fresh result
  assign dv_edge      = i_xts_data_valid && !dv_prev_q;
  assign wd_expired   = (wdog_q == WD_W'(TIMEOUT - 1));
  assign enter_finish = (state_d == S_FINISH) && (state_q != S_FINISH);

  // next-state and per-cycle event strobes; abort takes priority everywhere
  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    start_run = 1'b0;
    hit       = 1'b0;
    miss      = 1'b0;
    to_evt    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start && !i_abort) begin
          start_run = 1'b1;
          state_d   = S_READY;
        end
      end
      S_READY: begin
        if (i_abort) state_d = S_FINISH;
        else if (count_q != '0) begin
          pop     = 1'b1;
          state_d = S_WAIT;
        end else if (last_seen_q) state_d = S_FINISH;
      end
      S_WAIT: begin
        if (i_abort) state_d = S_FINISH;
        else if (dv_edge) begin
          if (i_xts_compare_valid) begin
            hit     = 1'b1;
            state_d = S_FINISH;
          end else begin
            miss    = 1'b1;
            state_d = S_RECOVER;
          end
        end else if (wd_expired) begin
          to_evt  = 1'b1;
          state_d = S_FINISH;
        end
      end
      S_RECOVER: begin
        if (i_abort) state_d = S_FINISH;
        else if (rec_q) state_d = S_READY;
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // FIFO storage; contents are don't-care while the pointers say empty
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= i_cand_key;
  end

  // FIFO pointers/occupancy and last-candidate latch; start flushes
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      last_seen_q <= 1'b0;
    end else if (start_run) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      last_seen_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop)      count_q <= count_q + (AW+1)'(1);
      else if (!push && pop) count_q <= count_q - (AW+1)'(1);
      if (push && i_cand_last) last_seen_q <= 1'b1;
    end
  end

  // engine-facing key register, one-cycle key_valid, watchdog and edge detector
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      xts_key_q       <= '0;
      xts_key_valid_q <= 1'b0;
      wdog_q          <= '0;
      dv_prev_q       <= 1'b0;
      rec_q           <= 1'b0;
    end else begin
      xts_key_valid_q <= pop;
      if (pop) xts_key_q <= mem_q[rd_ptr_q];
      if (pop)                    wdog_q <= '0;
      else if (state_q == S_WAIT) wdog_q <= wdog_q + WD_W'(1);
      dv_prev_q <= (state_q == S_RECOVER) ? 1'b0 : i_xts_data_valid;
      rec_q     <= (state_q == S_RECOVER) && !rec_q;
    end
  end

  // run status, sticky result capture and saturating attempt counter
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      found_q       <= 1'b0;
      timeout_q     <= 1'b0;
      attempts_q    <= '0;
      match_key_q   <= '0;
      match_index_q <= '0;
      plain_q       <= '0;
      xts_data_q    <= '0;
    end else begin
      if (start_run) begin
        busy_q        <= 1'b1;
        done_q        <= 1'b0;
        found_q       <= 1'b0;
        timeout_q     <= 1'b0;
        attempts_q    <= '0;
        match_key_q   <= '0;
        match_index_q <= '0;
        plain_q       <= '0;
        xts_data_q    <= i_header;
      end
      if (enter_finish) begin
        busy_q <= 1'b0;
        done_q <= 1'b1;
      end
      if (to_evt) timeout_q <= 1'b1;
      if (hit) begin
        found_q       <= 1'b1;
        match_key_q   <= xts_key_q;
        match_index_q <= attempts_q;
        plain_q       <= i_xts_data;
      end
      if ((hit || miss) && (attempts_q != '1)) attempts_q <= attempts_q + IDX_W'(1);
    end
  end

  // engine runs only while a key is being issued or checked
  assign o_xts_rstn      = (state_q == S_READY) || (state_q == S_WAIT);
  assign o_xts_key_valid = xts_key_valid_q;
  assign o_xts_key       = xts_key_q;
  assign o_xts_data      = xts_data_q;
  assign o_busy          = busy_q;
  assign o_done          = done_q;
  assign o_found         = found_q;
  assign o_timeout       = timeout_q;
  assign o_match_key     = match_key_q;
  assign o_match_index   = match_index_q;
  assign o_attempts      = attempts_q;
  assign o_plain         = plain_q;
endmodule

// File: tb/tb_xts_key_scheduler.sv
// Bench for xts_key_scheduler: a behavioural serpent_xts stand-in answers each
// issued key after a fixed latency; a scenario table drives full runs and a few
// hand-written sequences cover timeout, abort and mid-run reset.
module tb_xts_key_scheduler;
  localparam int DEPTH = 4;
  localparam int IW    = 32;
  localparam int TO    = 64;
  localparam int LAT   = 5;

  logic           i_clk = 1'b0;
  logic           i_rstn = 1'b0;
  logic           i_start = 1'b0, i_abort = 1'b0;
  logic [127:0]   i_header = '0;
  logic           i_cand_valid = 1'b0, i_cand_last = 1'b0;
  logic [511:0]   i_cand_key = '0;
  logic           o_cand_ready, o_xts_rstn, o_xts_key_valid;
  logic [511:0]   o_xts_key, o_match_key;
  logic [127:0]   o_xts_data, o_plain;
  logic           i_xts_data_valid, i_xts_compare_valid;
  logic [127:0]   i_xts_data;
  logic           o_busy, o_done, o_found, o_timeout;
  logic [IW-1:0]  o_match_index, o_attempts;

  xts_key_scheduler #(.FIFO_DEPTH(DEPTH), .IDX_W(IW), .TIMEOUT(TO)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_start(i_start), .i_abort(i_abort),
    .i_header(i_header), .i_cand_valid(i_cand_valid), .o_cand_ready(o_cand_ready),
    .i_cand_key(i_cand_key), .i_cand_last(i_cand_last), .o_xts_rstn(o_xts_rstn),
    .o_xts_key_valid(o_xts_key_valid), .o_xts_key(o_xts_key), .o_xts_data(o_xts_data),
    .i_xts_data_valid(i_xts_data_valid), .i_xts_compare_valid(i_xts_compare_valid),
    .i_xts_data(i_xts_data), .o_busy(o_busy), .o_done(o_done), .o_found(o_found),
    .o_timeout(o_timeout), .o_match_key(o_match_key), .o_match_index(o_match_index),
    .o_attempts(o_attempts), .o_plain(o_plain)
  );

  always #5 i_clk = ~i_clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] kv(input int s, input int i);
    logic [31:0] w;
    w = 32'(s * 256 + i) ^ 32'h5A5A_0000;
    return {16{w}};
  endfunction

  function automatic logic [127:0] hv(input int s);
    logic [31:0] w;
    w = 32'hE0C0_0000 + 32'(s);
    return {4{w}};
  endfunction

  // engine stand-in: sticky result LAT cycles after key_valid, cleared by soft reset
  logic         mdl_hang = 1'b0, mdl_match_en = 1'b0;
  logic [511:0] mdl_target = '0, m_key;
  logic         m_armed;
  int           m_cnt;
  always @(posedge i_clk) begin
    if (!o_xts_rstn) begin
      i_xts_data_valid    <= 1'b0;
      i_xts_compare_valid <= 1'b0;
      i_xts_data          <= '0;
      m_armed             <= 1'b0;
      m_cnt               <= 0;
    end else if (o_xts_key_valid) begin
      m_armed <= 1'b1;
      m_cnt   <= 0;
      m_key   <= o_xts_key;
    end else if (m_armed && !mdl_hang) begin
      if (m_cnt == LAT) begin
        m_armed             <= 1'b0;
        i_xts_data_valid    <= 1'b1;
        i_xts_compare_valid <= mdl_match_en && (m_key == mdl_target);
        i_xts_data          <= m_key[127:0] ^ o_xts_data;
      end else m_cnt <= m_cnt + 1;
    end
  end

  // monitor: issued keys, engine-reset gap lengths, producer stall cycles
  logic [511:0] issued[$];
  int           gaps[$];
  int           low_len = 0, ready_low = 0;
  logic         rstn_prev = 1'b0;
  always @(posedge i_clk) begin
    if (o_xts_key_valid) issued.push_back(o_xts_key);
    if (!o_xts_rstn) low_len <= low_len + 1;
    else begin
      if (!rstn_prev && o_attempts != '0) gaps.push_back(low_len);
      low_len <= 0;
    end
    rstn_prev <= o_xts_rstn;
    if (o_busy && i_cand_valid && !o_cand_ready) ready_low <= ready_low + 1;
  end

  task automatic start_run(input logic [127:0] h);
    @(negedge i_clk);
    i_header = h;
    i_start  = 1'b1;
    @(negedge i_clk);
    i_start  = 1'b0;
    i_header = '0;
  endtask

  // push n keys, holding each until accepted; stop early if the run ends
  task automatic produce(input int s, input int n);
    for (int i = 0; i < n; i++) begin
      int w;
      w = 0;
      i_cand_valid = 1'b1;
      i_cand_key   = kv(s, i);
      i_cand_last  = (i == n - 1);
      while (!o_cand_ready && !o_done && w < 3000) begin
        @(negedge i_clk);
        w++;
      end
      if (!o_cand_ready) break;
      @(posedge i_clk);
      #1;
    end
    i_cand_valid = 1'b0;
    i_cand_last  = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int cyc;
    cyc = 0;
    while (!o_done && cyc < 20000) begin
      @(negedge i_clk);
      cyc++;
    end
    chk(name, o_done, 1'b1);
  endtask

  task automatic wait_sig_kv(input string name);
    int w;
    w = 0;
    while (!o_xts_key_valid && w < 100) begin
      @(negedge i_clk);
      w++;
    end
    chk(name, o_xts_key_valid, 1'b1);
  endtask

  typedef struct {
    int   n;
    int   midx;
    int   exp_att;
    logic exp_found;
  } vec_t;

  task automatic run(input int s, input vec_t v);
    int base_i, base_g, base_r;
    logic [511:0] ek;
    logic [127:0] ep;
    base_i = issued.size();
    base_g = gaps.size();
    base_r = ready_low;
    mdl_match_en = (v.midx >= 0);
    mdl_target   = (v.midx >= 0) ? kv(s, v.midx) : '0;
    start_run(hv(s));
    chk("busy_after_start", o_busy, 1'b1);
    chk("done_cleared", o_done, 1'b0);
    chk("header_latched", o_xts_data, hv(s));
    fork
      produce(s, v.n);
      wait_done("run_done");
    join
    ek = v.exp_found ? kv(s, v.midx) : '0;
    ep = v.exp_found ? (ek[127:0] ^ hv(s)) : '0;
    chk("found", o_found, v.exp_found);
    chk("attempts", o_attempts, IW'(v.exp_att));
    chk("busy_at_done", o_busy, 1'b0);
    chk("timeout_flag", o_timeout, 1'b0);
    chk("match_key", o_match_key, ek);
    chk("match_index", o_match_index, v.exp_found ? IW'(v.midx) : '0);
    chk("plain", o_plain, ep);
    chk("issue_count", 32'(issued.size() - base_i), 32'(v.exp_att));
    for (int j = 0; j < v.exp_att && base_i + j < issued.size(); j++)
      chk("issue_order", issued[base_i + j], kv(s, j));
    chk("gap_count", 32'(gaps.size() - base_g), 32'(v.exp_att - int'(v.exp_found)));
    for (int j = base_g; j < gaps.size(); j++) chk("xts_rstn_gap", 32'(gaps[j]), 32'd2);
    if (v.n > DEPTH + 1) chk("backpressure", (ready_low - base_r) > 0, 1'b1);
    @(negedge i_clk);
  endtask

  vec_t tbl[5];

  initial begin
    int k;
    tbl[0] = '{3, -1, 3, 1'b0};
    tbl[1] = '{3,  1, 2, 1'b1};
    tbl[2] = '{6, -1, 6, 1'b0};
    tbl[3] = '{1,  0, 1, 1'b1};
    tbl[4] = '{4,  3, 4, 1'b1};

    // reset state
    repeat (3) @(negedge i_clk);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_done", o_done, 1'b0);
    chk("rst_xts_rstn", o_xts_rstn, 1'b0);
    chk("rst_cand_ready", o_cand_ready, 1'b0);
    chk("rst_key_valid", o_xts_key_valid, 1'b0);
    chk("rst_attempts", o_attempts, '0);
    i_rstn = 1'b1;
    @(negedge i_clk);

    for (int t = 0; t < 5; t++) run(t + 1, tbl[t]);

    // engine never answers: timeout after exactly TO cycles in WAIT
    mdl_hang = 1'b1;
    mdl_match_en = 1'b0;
    start_run(hv(10));
    produce(10, 1);
    wait_sig_kv("to_key_valid");
    k = 0;
    while (!o_done && k < 4 * TO) begin
      @(negedge i_clk);
      k++;
    end
    chk("to_latency", 32'(k), 32'(TO));
    chk("to_flag", o_timeout, 1'b1);
    chk("to_done", o_done, 1'b1);
    chk("to_attempts", o_attempts, '0);
    chk("to_found", o_found, 1'b0);
    mdl_hang = 1'b0;
    @(negedge i_clk);

    // abort coincident with the engine result edge
    mdl_match_en = 1'b1;
    mdl_target   = kv(11, 0);
    start_run(hv(11));
    produce(11, 1);
    k = 0;
    while (!i_xts_data_valid && k < 100) begin
      @(negedge i_clk);
      k++;
    end
    chk("ab_result_seen", i_xts_data_valid, 1'b1);
    i_abort = 1'b1;
    @(negedge i_clk);
    i_abort = 1'b0;
    chk("ab_done", o_done, 1'b1);
    chk("ab_found", o_found, 1'b0);
    chk("ab_attempts", o_attempts, '0);
    chk("ab_busy", o_busy, 1'b0);
    chk("ab_match_key", o_match_key, '0);
    @(negedge i_clk);

    // start ignored while busy, then async reset mid-WAIT
    mdl_hang = 1'b1;
    start_run(hv(12));
    produce(12, 1);
    wait_sig_kv("rs_key_valid");
    i_header = hv(99);
    i_start  = 1'b1;
    @(negedge i_clk);
    i_start  = 1'b0;
    @(negedge i_clk);
    chk("busy_start_ignored", o_xts_data, hv(12));
    chk("busy_still", o_busy, 1'b1);
    i_rstn = 1'b0;
    #1;
    chk("mid_rst_busy", o_busy, 1'b0);
    chk("mid_rst_xts_rstn", o_xts_rstn, 1'b0);
    chk("mid_rst_xts_key", o_xts_key, '0);
    chk("mid_rst_xts_data", o_xts_data, '0);
    chk("mid_rst_done", o_done, 1'b0);
    chk("mid_rst_cand_ready", o_cand_ready, 1'b0);
    @(negedge i_clk);
    i_rstn   = 1'b1;
    mdl_hang = 1'b0;
    @(negedge i_clk);
    run(13, '{2, 0, 1, 1'b1});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, %0d checks so far", n_chk);
    $fatal(1);
  end
endmodule
